// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction fetch port and a data port share one
// synchronous memory. Data normally has priority. A starvation counter makes sure
// fetch eventually gets a grant. Sub-word stores are done as read-modify-write
// of the word that starts at the store address.
module mem_arbiter #(
  parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_misaligned,
  // memory side
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  // A limit of 0 still needs a one-bit counter.
  localparam int unsigned CntW = (FETCH_STARVE_LIMIT < 1) ? 1 : $clog2(FETCH_STARVE_LIMIT + 1);

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        sel_fetch_q, sel_fetch_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [15:0] wdata_q, wdata_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_mis_q, d_mis_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        starved;
  logic        grant_data;
  logic        d_misalign;
  logic        d_word_store;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Arbitration and decode of the incoming data request.
  always_comb begin
    starved      = (cnt_q == CntW'(FETCH_STARVE_LIMIT));
    grant_data   = d_req && !(if_req && starved);
    // Size 2'b11 is treated like a word access.
    d_misalign   = ((d_size == 2'b01) && d_addr[0]) || (d_size[1] && (d_addr[1:0] != 2'b00));
    d_word_store = d_we && d_size[1];
  end

  // Load extension and sub-word store merge from the word returned by memory.
  always_comb begin
    load_data  = mem_data_out;
    merge_data = mem_data_out;
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & mem_data_out[7]}}, mem_data_out[7:0]};
      2'b01:   load_data = {{16{~uns_q & mem_data_out[15]}}, mem_data_out[15:0]};
      default: load_data = mem_data_out;
    endcase
    if (size_q == 2'b00) begin
      merge_data = {mem_data_out[31:8], wdata_q[7:0]};
    end else begin
      merge_data = {mem_data_out[31:16], wdata_q[15:0]};
    end
  end

  // Next-state logic; ready, misaligned and write strobes are single-cycle by default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_fetch_d = sel_fetch_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_mis_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      StIdle: begin
        if (!if_req) begin
          cnt_d = '0;
        end
        if (grant_data) begin
          if (if_req && !starved) begin
            cnt_d = cnt_q + 1'b1;
          end
          sel_fetch_d = 1'b0;
          we_d        = d_we;
          size_d      = d_size;
          uns_d       = d_unsigned;
          wdata_d     = d_wdata[15:0];
          if (d_misalign) begin
            // Error response without touching memory.
            state_d   = StResp;
            d_ready_d = 1'b1;
            d_mis_d   = 1'b1;
            d_rdata_d = '0;
          end else if (d_word_store) begin
            state_d     = StWr;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_rw_d    = 1'b1;
          end else begin
            state_d    = StRdAddr;
            mem_addr_d = d_addr;
          end
        end else if (if_req) begin
          cnt_d       = '0;
          sel_fetch_d = 1'b1;
          state_d     = StRdAddr;
          mem_addr_d  = if_addr;
        end
      end
      StRdAddr: state_d = StRdData;
      StRdData: begin
        if (sel_fetch_q) begin
          if_rdata_d = mem_data_out;
          if_ready_d = 1'b1;
          state_d    = StResp;
        end else if (we_q) begin
          mem_wdata_d = merge_data;
          mem_rw_d    = 1'b1;
          state_d     = StWr;
        end else begin
          d_rdata_d = load_data;
          d_ready_d = 1'b1;
          state_d   = StResp;
        end
      end
      StWr: begin
        d_ready_d = 1'b1;
        state_d   = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; synchronous reset drops any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_fetch_q <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_mis_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_rw_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_fetch_q <= sel_fetch_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
      d_mis_q     <= d_mis_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ready       = if_ready_q;
  assign if_rdata       = if_rdata_q;
  assign d_ready        = d_ready_q;
  assign d_rdata        = d_rdata_q;
  assign d_misaligned   = d_mis_q;
  assign mem_address    = mem_addr_q;
  assign mem_read_write = mem_rw_q;
  assign mem_data_in    = mem_wdata_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-addressed memory model returning the little-endian
// word starting at the sampled address, a table of single transactions, and
// hand-written sequences for arbitration fairness and mid-transaction reset.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_misaligned;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        busy;

  mem_arbiter #(.FETCH_STARVE_LIMIT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_ready       (if_ready),
    .if_rdata       (if_rdata),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_size         (d_size),
    .d_unsigned     (d_unsigned),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_ready        (d_ready),
    .d_rdata        (d_rdata),
    .d_misaligned   (d_misaligned),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Memory model: 256 bytes aliased over the address space.
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  logic       preload;
  int         wr_cycles = 0;

  always @(posedge clock) begin
    a0 = mem_address[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    mem_data_out <= {mem[a3], mem[a2], mem[a1], mem[a0]};
    if (mem_read_write) wr_cycles++;
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'hEF;
      mem[1] = 8'hBE;
      mem[2] = 8'hAD;
      mem[3] = 8'hDE;
    end else if (mem_read_write) begin
      mem[a0] = mem_data_in[7:0];
      mem[a1] = mem_data_in[15:8];
      mem[a2] = mem_data_in[23:16];
      mem[a3] = mem_data_in[31:24];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        mis;
    int          writes;
  } vec_t;

  vec_t vecs [15];

  // Starts and ends at a negedge with the DUT idle.
  task automatic run_txn(input vec_t t, output int lat, output logic [31:0] rdata,
                         output logic mis, output logic other, output int writes);
    int w0;
    w0  = wr_cycles;
    lat = -1;
    rdata = '0;
    mis = 1'b0;
    other = 1'b0;
    if (t.fetch) begin
      if_req  = 1'b1;
      if_addr = t.addr;
    end else begin
      d_req      = 1'b1;
      d_we       = t.we;
      d_size     = t.size;
      d_unsigned = t.uns;
      d_addr     = t.addr;
      d_wdata    = t.wdata;
    end
    @(posedge clock);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (if_ready || d_ready) begin
        lat   = k;
        rdata = t.fetch ? if_rdata : d_rdata;
        mis   = d_misaligned;
        other = t.fetch ? d_ready : if_ready;
        break;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    writes = wr_cycles - w0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          writes;
    logic [31:0] rdata;
    logic        mis;
    logic        other;
    logic [9:0]  order;
    int          n;
    int          w0;
    int          dready_seen;

    //              fetch we    size   uns   addr          wdata         lat rdata         mis   wr
    vecs[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h01000000, 32'h00000000, 2, 32'hDEADBEEF, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h01000000, 32'h00000000, 2, 32'hFFFFFFEF, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h01000002, 32'h00000000, 2, 32'h0000DEAD, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h01000002, 32'h00000000, 2, 32'hFFFFDEAD, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h01000001, 32'h00000000, 2, 32'h000000BE, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h01000001, 32'h00000055, 3, 32'h000000BE, 1'b0, 1};
    vecs[6]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h01000000, 32'h00000000, 2, 32'hDEAD55EF, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h01000002, 32'h00000000, 0, 32'h00000000, 1'b1, 0};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h01000004, 32'h12345678, 1, 32'h00000000, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h01000004, 32'h00000000, 2, 32'h00005678, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h01000006, 32'hFFFFABCD, 3, 32'h00005678, 1'b0, 1};
    vecs[11] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h01000004, 32'h00000000, 2, 32'hABCD5678, 1'b0, 0};
    vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h01000005, 32'h00001111, 0, 32'h00000000, 1'b1, 0};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h01000007, 32'h00000000, 2, 32'hFFFFFFAB, 1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h01000004, 32'h00000000, 2, 32'hABCD5678, 1'b0, 0};

    reset = 1'b1;
    preload = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_size = 2'b00;
    d_unsigned = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    preload = 1'b0;

    // Reset values.
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_readys", {30'b0, if_ready, d_ready}, 32'd0);
    check("rst_mis_rw", {30'b0, d_misaligned, mem_read_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);

    // Single transactions.
    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i], lat, rdata, mis, other, writes);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      check($sformatf("v%0d_misaligned", i), {31'b0, mis}, {31'b0, vecs[i].mis});
      check($sformatf("v%0d_other_ready", i), {31'b0, other}, 32'd0);
      check($sformatf("v%0d_write_cycles", i), 32'(writes), 32'(vecs[i].writes));
    end

    // Both ports requesting continuously: fetch gets every fifth grant.
    if_req     = 1'b1;
    if_addr    = 32'h01000000;
    d_req      = 1'b1;
    d_we       = 1'b0;
    d_size     = 2'b10;
    d_unsigned = 1'b0;
    d_addr     = 32'h01000000;
    order = '0;
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clock);
      if (if_ready) begin
        order[n] = 1'b1;
        n++;
      end else if (d_ready) begin
        n++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check("starve_grant_count", 32'(n), 32'd10);
    check("starve_grant_order", {22'b0, order}, 32'h00000210);
    repeat (2) @(negedge clock);

    // Reset while a byte store sits in RD_DATA: no write, no response.
    w0 = wr_cycles;
    dready_seen = 0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_size  = 2'b00;
    d_addr  = 32'h01000000;
    d_wdata = 32'h00000099;
    @(posedge clock);
    @(negedge clock);
    if (d_ready) dready_seen++;
    @(posedge clock);
    @(negedge clock);
    if (d_ready) dready_seen++;
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    d_req = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_flags", {28'b0, if_ready, d_ready, d_misaligned, mem_read_write}, 32'd0);
    check("midrst_mem_address", mem_address, 32'd0);
    check("midrst_mem_data_in", mem_data_in, 32'd0);
    check("midrst_rdata", if_rdata | d_rdata, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (d_ready) dready_seen++;
    end
    check("midrst_no_dready", 32'(dready_seen), 32'd0);
    check("midrst_no_write", 32'(wr_cycles - w0), 32'd0);
    check("midrst_mem_word", {mem[3], mem[2], mem[1], mem[0]}, 32'hDEAD55EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
